// File: rtl/spi_note_decoder_pkg.sv
// Shared constants, state encoding and voice-range helper for the SPI note command decoder.
package spi_note_decoder_pkg;

  localparam int NUM_VOICES_DEFAULT = 256;
  localparam int NOTE_ON_LEN        = 7;
  localparam int NOTE_OFF_LEN       = 2;
  localparam int TUNE_BYTES         = 4;

  localparam logic [7:0] OP_NOTE_ON  = 8'h90;
  localparam logic [7:0] OP_NOTE_OFF = 8'h80;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_VOICE = 3'd1,
    ST_VEL   = 3'd2,
    ST_TUNE  = 3'd3,
    ST_ISSUE = 3'd4,
    ST_DRAIN = 3'd5,
    ST_ERR   = 3'd6
  } state_t;

  function automatic logic voice_ok(input logic [7:0] voice, input int num_voices);
    return (int'(voice) < num_voices);
  endfunction

endpackage

// File: rtl/spi_note_decoder_if.sv
// Byte-receiver inputs and voice_controller command outputs of the note decoder.
interface spi_note_decoder_if;

  logic [7:0]  i_rx_byte;
  logic        i_rx_valid;
  logic        i_cs_n;
  logic [31:0] o_SPI_tuning_code;
  logic [7:0]  o_SPI_voice_index;
  logic [7:0]  o_SPI_velocity;
  logic        o_SPI_note_status;
  logic        o_SPI_flag_dds;
  logic        o_SPI_flag_adsr;
  logic        o_frame_error;
  logic        o_busy;

  modport master (
    output i_rx_byte, i_rx_valid, i_cs_n,
    input  o_SPI_tuning_code, o_SPI_voice_index, o_SPI_velocity, o_SPI_note_status,
    input  o_SPI_flag_dds, o_SPI_flag_adsr, o_frame_error, o_busy
  );

  modport slave (
    input  i_rx_byte, i_rx_valid, i_cs_n,
    output o_SPI_tuning_code, o_SPI_voice_index, o_SPI_velocity, o_SPI_note_status,
    output o_SPI_flag_dds, o_SPI_flag_adsr, o_frame_error, o_busy
  );

endinterface

// File: rtl/spi_note_decoder.sv
// Frames note-on / note-off byte streams into voice_controller commands; outputs change
// only on the clock that accepts a frame's final byte.
module spi_note_decoder
  import spi_note_decoder_pkg::*;
#(
  parameter int NUM_VOICES = NUM_VOICES_DEFAULT
) (
  input  logic             i_clk,
  input  logic             i_reset,
  spi_note_decoder_if.slave bus
);

  localparam logic [1:0] TUNE_LAST = 2'(TUNE_BYTES - 1);

  state_t      state_r;
  logic        is_on_r;
  logic [1:0]  cnt_r;
  logic [7:0]  voice_sh_r;
  logic [7:0]  vel_sh_r;
  logic [23:0] tune_sh_r;
  logic [31:0] tuning_r;
  logic [7:0]  voice_r;
  logic [7:0]  vel_r;
  logic        status_r;
  logic        dds_r;
  logic        adsr_r;
  logic        err_r;
  logic        busy_r;

  // Frame FSM with shadow capture; results are committed on entry to ST_ISSUE.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_r    <= ST_IDLE;
      is_on_r    <= 1'b0;
      cnt_r      <= 2'd0;
      voice_sh_r <= 8'd0;
      vel_sh_r   <= 8'd0;
      tune_sh_r  <= 24'd0;
      tuning_r   <= 32'd0;
      voice_r    <= 8'd0;
      vel_r      <= 8'd0;
      status_r   <= 1'b0;
      dds_r      <= 1'b0;
      adsr_r     <= 1'b0;
      err_r      <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      dds_r  <= 1'b0;
      adsr_r <= 1'b0;
      err_r  <= 1'b0;
      busy_r <= 1'b1;
      // Chip-select release aborts silently; an issue already under way still completes.
      if (bus.i_cs_n && (state_r != ST_ISSUE)) begin
        state_r <= ST_IDLE;
        busy_r  <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (bus.i_rx_valid) begin
              if (bus.i_rx_byte == OP_NOTE_ON) begin
                is_on_r <= 1'b1;
                state_r <= ST_VOICE;
              end else if (bus.i_rx_byte == OP_NOTE_OFF) begin
                is_on_r <= 1'b0;
                state_r <= ST_VOICE;
              end else begin
                err_r   <= 1'b1;
                state_r <= ST_ERR;
              end
            end else begin
              busy_r <= 1'b0;
            end
          end
          ST_VOICE: begin
            if (bus.i_rx_valid) begin
              if (!voice_ok(bus.i_rx_byte, NUM_VOICES)) begin
                err_r   <= 1'b1;
                state_r <= ST_ERR;
              end else if (is_on_r) begin
                voice_sh_r <= bus.i_rx_byte;
                state_r    <= ST_VEL;
              end else begin
                voice_r  <= bus.i_rx_byte;
                status_r <= 1'b0;
                adsr_r   <= 1'b1;
                state_r  <= ST_ISSUE;
              end
            end
          end
          ST_VEL: begin
            if (bus.i_rx_valid) begin
              vel_sh_r <= bus.i_rx_byte;
              cnt_r    <= 2'd0;
              state_r  <= ST_TUNE;
            end
          end
          ST_TUNE: begin
            if (bus.i_rx_valid) begin
              if (cnt_r == TUNE_LAST) begin
                tuning_r <= {tune_sh_r, bus.i_rx_byte};
                voice_r  <= voice_sh_r;
                vel_r    <= vel_sh_r;
                status_r <= 1'b1;
                dds_r    <= 1'b1;
                adsr_r   <= 1'b1;
                state_r  <= ST_ISSUE;
              end else begin
                tune_sh_r <= {tune_sh_r[15:0], bus.i_rx_byte};
                cnt_r     <= cnt_r + 2'd1;
              end
            end
          end
          ST_ISSUE: begin
            if (bus.i_cs_n) begin
              state_r <= ST_IDLE;
              busy_r  <= 1'b0;
            end else begin
              state_r <= ST_DRAIN;
            end
          end
          ST_DRAIN, ST_ERR: begin
            state_r <= state_r;
          end
          default: begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.o_SPI_tuning_code = tuning_r;
  assign bus.o_SPI_voice_index = voice_r;
  assign bus.o_SPI_velocity    = vel_r;
  assign bus.o_SPI_note_status = status_r;
  assign bus.o_SPI_flag_dds    = dds_r;
  assign bus.o_SPI_flag_adsr   = adsr_r;
  assign bus.o_frame_error     = err_r;
  assign bus.o_busy            = busy_r;

endmodule

// File: tb/tb_spi_note_decoder.sv
// Scoreboard bench: two decoders (256 and 8 voices) share one byte stream; a frame-level
// reference model predicts strobes and held outputs, and a monitor compares every cycle.
module tb_spi_note_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cs_n = 1'b1;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_byte = 8'h00;

  always #5 clk = ~clk;

  spi_note_decoder_if if_a();
  spi_note_decoder_if if_b();

  assign if_a.i_cs_n = cs_n;
  assign if_a.i_rx_valid = rx_valid;
  assign if_a.i_rx_byte = rx_byte;
  assign if_b.i_cs_n = cs_n;
  assign if_b.i_rx_valid = rx_valid;
  assign if_b.i_rx_byte = rx_byte;

  spi_note_decoder #(.NUM_VOICES(256)) dut_a (.i_clk(clk), .i_reset(rst_n), .bus(if_a.slave));
  spi_note_decoder #(.NUM_VOICES(8))   dut_b (.i_clk(clk), .i_reset(rst_n), .bus(if_b.slave));

  localparam int K_ON = 0, K_OFF = 1, K_ERR = 2;
  typedef struct { int kind; int due; } exp_t;
  exp_t q0[$];
  exp_t q1[$];

  int          nv [2] = '{256, 8};
  logic [7:0]  fr [2][7];
  int          fr_len [2];
  bit          dead [2];
  logic [31:0] m_tun [2];
  logic [7:0]  m_voice [2];
  logic [7:0]  m_vel [2];
  logic        m_status [2];
  logic        m_busy [2];
  logic [7:0]  fb [10];

  int cyc = 0;
  int total = 0;
  int bad = 0;
  bit mon_on = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d got=%0h want=%0h t=%0t", name, d, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int d, input int kind);
    exp_t e;
    e.kind = kind;
    e.due  = cyc + 1;
    if (d == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic model_clear();
    for (int d = 0; d < 2; d++) begin
      fr_len[d] = 0; dead[d] = 1'b0; m_tun[d] = 32'd0; m_voice[d] = 8'd0;
      m_vel[d] = 8'd0; m_status[d] = 1'b0; m_busy[d] = 1'b0;
    end
    q0.delete();
    q1.delete();
  endtask

  // Frame-level model: collect bytes of the current chip-select window and decide on them.
  task automatic model_step(input int d, input logic cs, input logic v, input logic [7:0] b);
    if (cs) begin
      fr_len[d] = 0; dead[d] = 1'b0; m_busy[d] = 1'b0;
      return;
    end
    if (v && !dead[d]) begin
      fr[d][fr_len[d]] = b;
      fr_len[d]++;
      if (fr_len[d] == 1) begin
        if (b != 8'h90 && b != 8'h80) begin dead[d] = 1'b1; push_exp(d, K_ERR); end
      end else if (fr_len[d] == 2) begin
        if (int'(b) >= nv[d]) begin
          dead[d] = 1'b1; push_exp(d, K_ERR);
        end else if (fr[d][0] == 8'h80) begin
          m_voice[d] = b; m_status[d] = 1'b0; dead[d] = 1'b1; push_exp(d, K_OFF);
        end
      end else if (fr_len[d] == 7) begin
        m_tun[d] = {fr[d][3], fr[d][4], fr[d][5], fr[d][6]};
        m_voice[d] = fr[d][1]; m_vel[d] = fr[d][2]; m_status[d] = 1'b1;
        dead[d] = 1'b1; push_exp(d, K_ON);
      end
    end
    m_busy[d] = (fr_len[d] != 0);
  endtask

  task automatic drive(input logic cs, input logic v, input logic [7:0] b);
    @(negedge clk);
    cs_n = cs; rx_valid = v; rx_byte = b;
    for (int d = 0; d < 2; d++) model_step(d, cs, v, b);
  endtask

  task automatic send(input int n, input int gap_max);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(gap_max, 0)) drive(1'b0, 1'b0, 8'h00);
      drive(1'b0, 1'b1, fb[i]);
    end
    drive(1'b1, 1'($urandom_range(1, 0)), 8'($urandom));
    drive(1'b1, 1'b0, 8'h00);
  endtask

  task automatic set_fb(input logic [7:0] b0, b1, b2, b3, b4, b5, b6);
    fb[0] = b0; fb[1] = b1; fb[2] = b2; fb[3] = b3; fb[4] = b4; fb[5] = b5; fb[6] = b6;
  endtask

  task automatic check_zero(input int d, input logic [31:0] tun, input logic [7:0] vo, ve,
                            input logic st, dds, adsr, err, busy);
    chk("rst_tuning", d, tun, 32'd0);
    chk("rst_voice", d, 32'(vo), 32'd0);
    chk("rst_velocity", d, 32'(ve), 32'd0);
    chk("rst_flags", d, 32'({st, dds, adsr, err, busy}), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; cs_n = 1'b1; rx_valid = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    check_zero(0, if_a.o_SPI_tuning_code, if_a.o_SPI_voice_index, if_a.o_SPI_velocity,
               if_a.o_SPI_note_status, if_a.o_SPI_flag_dds, if_a.o_SPI_flag_adsr,
               if_a.o_frame_error, if_a.o_busy);
    check_zero(1, if_b.o_SPI_tuning_code, if_b.o_SPI_voice_index, if_b.o_SPI_velocity,
               if_b.o_SPI_note_status, if_b.o_SPI_flag_dds, if_b.o_SPI_flag_adsr,
               if_b.o_frame_error, if_b.o_busy);
    rst_n = 1'b1;
  endtask

  task automatic check_dut(input int d, input logic dds, adsr, err, st, input logic [31:0] tun,
                           input logic [7:0] vo, ve, input logic busy);
    exp_t e;
    bit   have;
    int   code;
    have = (d == 0) ? (q0.size() > 0) : (q1.size() > 0);
    if (have) e = (d == 0) ? q0[0] : q1[0];
    if (have) code = (e.kind == K_ON) ? 3'b110 : (e.kind == K_OFF) ? 3'b010 : 3'b001;
    else code = 0;
    if (dds || adsr || err || (have && cyc >= e.due)) begin
      chk("strobes", d, 32'({dds, adsr, err}), 32'(code));
      if (have) begin
        chk("strobe_latency", d, 32'(cyc), 32'(e.due));
        if (d == 0) void'(q0.pop_front());
        else void'(q1.pop_front());
      end
    end
    chk("tuning", d, tun, m_tun[d]);
    chk("voice", d, 32'(vo), 32'(m_voice[d]));
    chk("velocity", d, 32'(ve), 32'(m_vel[d]));
    chk("status", d, 32'(st), 32'(m_status[d]));
    chk("busy", d, 32'(busy), 32'(m_busy[d]));
  endtask

  // Monitor: sample both decoders shortly after each active edge.
  always @(posedge clk) begin
    #2;
    if (mon_on) begin
      check_dut(0, if_a.o_SPI_flag_dds, if_a.o_SPI_flag_adsr, if_a.o_frame_error,
                if_a.o_SPI_note_status, if_a.o_SPI_tuning_code, if_a.o_SPI_voice_index,
                if_a.o_SPI_velocity, if_a.o_busy);
      check_dut(1, if_b.o_SPI_flag_dds, if_b.o_SPI_flag_adsr, if_b.o_frame_error,
                if_b.o_SPI_note_status, if_b.o_SPI_tuning_code, if_b.o_SPI_voice_index,
                if_b.o_SPI_velocity, if_b.o_busy);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v;
    int         r;
    int         n;
    do_reset();
    mon_on = 1'b1;

    // Note on, then note off of the same voice.
    set_fb(8'h90, 8'hFD, 8'h64, 8'h01, 8'h31, 8'h2D, 8'h00);
    send(7, 0);
    chk("t1_tuning", 0, if_a.o_SPI_tuning_code, 32'd20_000_000);
    chk("t1_voice", 0, 32'(if_a.o_SPI_voice_index), 32'd253);
    chk("t1_velocity", 0, 32'(if_a.o_SPI_velocity), 32'd100);
    chk("t1_status", 0, 32'(if_a.o_SPI_note_status), 32'd1);
    fb[0] = 8'h80; fb[1] = 8'hFD;
    send(2, 0);
    chk("t2_status", 0, 32'(if_a.o_SPI_note_status), 32'd0);
    chk("t2_voice", 0, 32'(if_a.o_SPI_voice_index), 32'd253);
    chk("t2_tuning", 0, if_a.o_SPI_tuning_code, 32'd20_000_000);

    // Abort, then a full frame.
    set_fb(8'h90, 8'h05, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00);
    send(3, 0);
    set_fb(8'h90, 8'h02, 8'h7F, 8'h00, 8'h00, 8'h10, 8'h00);
    send(7, 1);
    chk("t3_tuning", 0, if_a.o_SPI_tuning_code, 32'h0000_1000);

    // Bad opcode followed by bytes that look like a frame.
    set_fb(8'h42, 8'h90, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00);
    send(3, 0);

    // Voice range limit on the 8-voice decoder.
    fb[0] = 8'h80; fb[1] = 8'h09;
    send(2, 0);
    fb[1] = 8'h07;
    send(2, 0);
    chk("t5_voice", 1, 32'(if_b.o_SPI_voice_index), 32'd7);

    // Reset in the middle of a note on, then a fresh note on.
    set_fb(8'h90, 8'h03, 8'h50, 8'hAA, 8'h00, 8'h00, 8'h00);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, fb[i]);
    do_reset();
    set_fb(8'h90, 8'h06, 8'h22, 8'hDE, 8'hAD, 8'hBE, 8'hEF);
    send(7, 2);
    chk("t6_tuning", 1, if_b.o_SPI_tuning_code, 32'hDEAD_BEEF);

    // Randomized frames of every kind.
    for (int k = 0; k < 200; k++) begin
      r = $urandom_range(5, 0);
      v = ($urandom_range(1, 0) != 0) ? 8'($urandom_range(7, 0)) : 8'($urandom);
      for (int i = 0; i < 10; i++) fb[i] = 8'($urandom);
      fb[1] = v;
      n = 7;
      case (r)
        0, 1: fb[0] = 8'h90;
        2: begin fb[0] = 8'h80; n = 2; end
        3: begin
          if (fb[0] == 8'h90 || fb[0] == 8'h80) fb[0] = 8'h42;
          n = $urandom_range(4, 1);
        end
        4: begin fb[0] = 8'h90; n = $urandom_range(6, 1); end
        default: begin fb[0] = ($urandom_range(1, 0) != 0) ? 8'h90 : 8'h80; n = 10; end
      endcase
      send(n, 2);
    end

    repeat (3) drive(1'b1, 1'b0, 8'h00);
    chk("queue_empty", 0, 32'(q0.size()), 32'd0);
    chk("queue_empty", 1, 32'(q1.size()), 32'd0);
    mon_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
